// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm
// Main control state machine for a multi-cycle RV32I core supporting lw, sw,
// R-type, I-type ALU, beq and jal. Produces the per-cycle register enables and
// datapath mux selects. A wait counter stretches FETCH and MEMREAD by MEM_WAIT
// extra cycles so slow memories can be used.
//
// Parameters
//   MEM_WAIT      extra cycles (0..15) spent in FETCH and MEMREAD
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   op_i          opcode field of the latched instruction
//   zero_i        ALU zero flag (used only by beq)
//   pc_write_o    PC register enable
//   adr_src_o     memory address select: 0=PC, 1=ALU result register
//   mem_write_o   data memory write enable
//   ir_write_o    instruction/old-PC latch enable
//   reg_write_o   register file write enable
//   result_src_o  result mux: 00=ALUOut, 01=mem data, 10=ALU result
//   alu_src_a_o   ALU A select: 00=PC, 01=oldPC, 10=rs1 latch
//   alu_src_b_o   ALU B select: 00=rs2 latch, 01=immediate, 10=constant 4
//   alu_op_o      ALU control: 00=add, 01=sub/compare, 10=decode by funct
//   illegal_op_o  one-cycle pulse in DECODE on an unsupported opcode
//   state_o       current state encoding (debug)
// -----------------------------------------------------------------------------
module mc_ctrl_fsm #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op_i,
  input  logic       zero_i,
  output logic       pc_write_o,
  output logic       adr_src_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       illegal_op_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // Counter value marking the final cycle of a stretched state.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write_o   = 1'b0;
    adr_src_o    = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    result_src_o = 2'b00;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    illegal_op_o = 1'b0;

    case (state_q)
      FETCH: begin
        // ALU computes PC+4 every fetch cycle; it is only committed on the last.
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b10;
        alu_op_o     = 2'b00;
        result_src_o = 2'b10;
        if (cnt_q == WAIT_LAST) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          cnt_d      = '0;
          state_d    = DECODE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      DECODE: begin
        // oldPC + immediate is the branch/jump target, ready for BEQ/JAL.
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        alu_op_o    = 2'b00;
        case (op_i)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default: begin
            illegal_op_o = 1'b1;
            state_d      = FETCH;
          end
        endcase
      end

      MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_op_o    = 2'b00;
        state_d     = (op_i == OP_LW) ? MEMREAD : MEMWRITE;
      end

      MEMREAD: begin
        adr_src_o    = 1'b1;
        result_src_o = 2'b00;
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = MEMWB;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      MEMWB: begin
        result_src_o = 2'b01;
        reg_write_o  = 1'b1;
        state_d      = FETCH;
      end

      MEMWRITE: begin
        adr_src_o   = 1'b1;
        mem_write_o = 1'b1;
        state_d     = FETCH;
      end

      EXECR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b00;
        alu_op_o    = 2'b10;
        state_d     = ALUWB;
      end

      EXECI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_op_o    = 2'b10;
        state_d     = ALUWB;
      end

      ALUWB: begin
        result_src_o = 2'b00;
        reg_write_o  = 1'b1;
        state_d      = FETCH;
      end

      BEQ: begin
        // Compare rs1-rs2; ALUOut still holds the target computed in DECODE.
        alu_src_a_o  = 2'b10;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b01;
        result_src_o = 2'b00;
        pc_write_o   = zero_i;
        state_d      = FETCH;
      end

      JAL: begin
        // Jump to ALUOut target while the ALU forms oldPC+4 for the link write.
        alu_src_a_o  = 2'b01;
        alu_src_b_o  = 2'b10;
        alu_op_o     = 2'b00;
        result_src_o = 2'b00;
        pc_write_o   = 1'b1;
        state_d      = ALUWB;
      end

      default: begin
        state_d = FETCH;
        cnt_d   = '0;
      end
    endcase

    // Reset suppresses every enable so nothing is committed mid-abort.
    if (rst) begin
      pc_write_o   = 1'b0;
      ir_write_o   = 1'b0;
      mem_write_o  = 1'b0;
      reg_write_o  = 1'b0;
      illegal_op_o = 1'b0;
    end
  end

  assign state_o = state_q;

endmodule
